ama_riscv_pipeline_ctrl: RTL and testbench

Pipeline hazard and flush controller for the AMA-RISCV 5-stage core. It consumes hazard-relevant fields from the instruction decoder (ID stage) and the branch/jump resolution result from EX. It sequences the pipeline-register control signals: IF/ID stall, bubble insertion, and wrong-path flushes. It also runs a post-reset pipeline-flush sequence and keeps a bubble performance counter.

---
 rtl/ama_riscv_pipeline_ctrl.sv | 127 ++++++++++++
 tb/tb_ama_riscv_pipeline_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_pipeline_ctrl.sv
// Pipeline hazard/flush controller for the AMA-RISCV 5-stage core: load-use stalls,
// branch/JALR resolution wait with timeout, JAL fetch flush, post-reset flush and bubble counter.
module ama_riscv_pipeline_ctrl #(
    parameter int INIT_CYCLES = 3,
    parameter int MAX_WAIT    = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch_id,
    input  logic             jalr_id,
    input  logic             jal_id,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic             load_ex,
    input  logic [4:0]       rd_ex,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             stall_if,
    output logic             stall_id,
    output logic             clear_if,
    output logic             clear_id,
    output logic             clear_ex,
    output logic             ctrl_busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_WAIT} state_t;

    state_t            state, state_nxt;
    logic [INIT_W-1:0] init_cnt, init_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              timeout_q, timeout_now;
    logic [CNT_W-1:0]  bubble_q;
    logic              load_use, bubble_inc;

    assign load_use = load_ex && (rd_ex != 5'd0) &&
                      ((rs1_used_id && (rs1_id == rd_ex)) || (rs2_used_id && (rs2_id == rd_ex)));

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        wait_cnt_nxt = wait_cnt;
        timeout_now  = 1'b0;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        clear_if     = 1'b0;
        clear_id     = 1'b0;
        clear_ex     = 1'b0;
        ctrl_busy    = 1'b0;

        case (state)
            ST_INIT: begin
                {stall_if, clear_if, clear_id, clear_ex, ctrl_busy} = 5'b11111;
                if (init_cnt == INIT_LAST) begin
                    state_nxt    = ST_RUN;
                    init_cnt_nxt = '0;
                end else begin
                    init_cnt_nxt = init_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                // Load-use blocks control flow; a waiting branch is taken up next cycle.
                if (load_use) begin
                    {stall_if, stall_id, clear_ex} = 3'b111;
                end else if (branch_id || jalr_id) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = '0;
                end else if (jal_id) begin
                    clear_if = 1'b1;
                end
            end
            ST_WAIT: begin
                {stall_if, clear_id, ctrl_busy} = 3'b111;
                if (resolve_valid) begin
                    stall_if  = 1'b0;
                    clear_if  = resolve_taken;
                    state_nxt = ST_RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    stall_if    = 1'b0;
                    clear_if    = 1'b1;
                    timeout_now = 1'b1;
                    state_nxt   = ST_RUN;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_INIT;
        endcase

        if (rst) begin
            {stall_if, clear_if, clear_id, clear_ex, ctrl_busy} = 5'b11111;
            stall_id = 1'b0;
        end
    end

    assign bubble_inc  = (state != ST_INIT) && (clear_id || clear_ex);
    assign timeout_err = !rst && (timeout_q || timeout_now);
    assign bubble_cnt  = rst ? '0 : bubble_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            bubble_q  <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_now) timeout_q <= 1'b1;
            if (bubble_inc)  bubble_q  <= bubble_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_ama_riscv_pipeline_ctrl.sv
// Scoreboard bench for ama_riscv_pipeline_ctrl: per-cycle expected outputs are queued when
// stimulus is driven and compared on the following falling edge.
module tb_ama_riscv_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_id = 0, jalr_id = 0, jal_id = 0;
    logic [4:0]  rs1_id = 0, rs2_id = 0, rd_ex = 0;
    logic        rs1_used_id = 0, rs2_used_id = 0, load_ex = 0;
    logic        resolve_valid = 0, resolve_taken = 0;
    logic        stall_if, stall_id, clear_if, clear_id, clear_ex, ctrl_busy, timeout_err;
    logic [31:0] bubble_cnt;

    ama_riscv_pipeline_ctrl #(.INIT_CYCLES(3), .MAX_WAIT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .branch_id(branch_id), .jalr_id(jalr_id), .jal_id(jal_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .load_ex(load_ex), .rd_ex(rd_ex),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .stall_if(stall_if), .stall_id(stall_id), .clear_if(clear_if), .clear_id(clear_id),
        .clear_ex(clear_ex), .ctrl_busy(ctrl_busy), .timeout_err(timeout_err),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Output vector order: {stall_if, stall_id, clear_if, clear_id, clear_ex, ctrl_busy, timeout_err}
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_INIT  = 7'b1011110;
    localparam logic [6:0] O_LU    = 7'b1100100;
    localparam logic [6:0] O_WAIT  = 7'b1001010;
    localparam logic [6:0] O_RES_T = 7'b0011010;
    localparam logic [6:0] O_RES_N = 7'b0001010;
    localparam logic [6:0] O_TMO   = 7'b0011011;
    localparam logic [6:0] O_JAL   = 7'b0010000;

    typedef struct {
        string       tag;
        logic [6:0]  outs;
        logic [31:0] bub;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_bub  = 0;
    logic        te       = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge and return all inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        rst = 0; branch_id = 0; jalr_id = 0; jal_id = 0;
        rs1_id = 0; rs2_id = 0; rs1_used_id = 0; rs2_used_id = 0;
        load_ex = 0; rd_ex = 0; resolve_valid = 0; resolve_taken = 0;
    endtask

    // Queue the expected outputs for the cycle just driven; bubbles count outside INIT/reset.
    task automatic expect_o(input string tag, input logic [6:0] o, input bit init_cyc);
        exp_t e;
        e.tag  = tag;
        e.outs = o | {6'b0, te};
        e.bub  = exp_bub;
        sb.push_back(e);
        if (!init_cyc && (o[3] || o[2])) exp_bub++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".outs"},
                  {57'b0, stall_if, stall_id, clear_if, clear_id, clear_ex, ctrl_busy, timeout_err},
                  {57'b0, e.outs});
            check({e.tag, ".bubble"}, {32'b0, bubble_cnt}, {32'b0, e.bub});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held, then three INIT cycles after release.
        tick(); rst = 1; expect_o("rst_hold0", O_INIT, 1);
        tick(); rst = 1; expect_o("rst_hold1", O_INIT, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_o($sformatf("init%0d", i), O_INIT, 1);
        end
        tick(); expect_o("run_idle", O_IDLE, 0);

        // Load-use on rs2, then rd_ex=0 (no hazard), then rs1 match and a non-used rs1.
        tick(); load_ex = 1; rd_ex = 5; rs2_used_id = 1; rs2_id = 5; expect_o("lu_rs2", O_LU, 0);
        tick(); expect_o("lu_after", O_IDLE, 0);
        tick(); load_ex = 1; rd_ex = 0; rs2_used_id = 1; rs2_id = 0; expect_o("lu_x0", O_IDLE, 0);
        tick(); load_ex = 1; rd_ex = 7; rs1_used_id = 1; rs1_id = 7; expect_o("lu_rs1", O_LU, 0);
        tick(); load_ex = 1; rd_ex = 7; rs1_used_id = 0; rs1_id = 7; expect_o("lu_unused", O_IDLE, 0);

        // Branch resolved taken two cycles after entering WAIT, then not taken.
        tick(); branch_id = 1; expect_o("br_t_id", O_IDLE, 0);
        tick(); expect_o("br_t_wait", O_WAIT, 0);
        tick(); resolve_valid = 1; resolve_taken = 1; expect_o("br_t_res", O_RES_T, 0);
        tick(); expect_o("br_t_after", O_IDLE, 0);
        tick(); branch_id = 1; expect_o("br_n_id", O_IDLE, 0);
        tick(); expect_o("br_n_wait", O_WAIT, 0);
        tick(); resolve_valid = 1; resolve_taken = 0; expect_o("br_n_res", O_RES_N, 0);

        // Resolution in RUN is ignored.
        tick(); resolve_valid = 1; resolve_taken = 1; expect_o("res_in_run", O_IDLE, 0);

        // JALR resolved on the last allowed WAIT cycle: no timeout.
        tick(); jalr_id = 1; expect_o("jalr_late_id", O_IDLE, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_o($sformatf("jalr_late_w%0d", i), O_WAIT, 0);
        end
        tick(); resolve_valid = 1; resolve_taken = 1; expect_o("jalr_late_res", O_RES_T, 0);
        tick(); expect_o("jalr_late_after", O_IDLE, 0);

        // Load-use coincident with a branch: stall first, branch enters WAIT next cycle.
        tick(); load_ex = 1; rd_ex = 3; rs1_used_id = 1; rs1_id = 3; branch_id = 1;
        expect_o("lu_br_stall", O_LU, 0);
        tick(); branch_id = 1; expect_o("lu_br_go", O_IDLE, 0);
        tick(); resolve_valid = 1; expect_o("lu_br_res", O_RES_N, 0);

        // JAL with branch: branch wins, no JAL flush. Then a lone JAL.
        tick(); jal_id = 1; branch_id = 1; expect_o("jal_br_id", O_IDLE, 0);
        tick(); resolve_valid = 1; expect_o("jal_br_res", O_RES_N, 0);
        tick(); jal_id = 1; expect_o("jal", O_JAL, 0);
        tick(); expect_o("jal_after", O_IDLE, 0);

        // JALR with no resolution: timeout on the fourth WAIT cycle, flag stays set.
        tick(); jalr_id = 1; expect_o("tmo_id", O_IDLE, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_o($sformatf("tmo_w%0d", i), O_WAIT, 0);
        end
        tick(); expect_o("tmo_exit", O_TMO, 0);
        te = 1'b1;
        tick(); expect_o("tmo_sticky", O_IDLE, 0);

        // Reset mid-WAIT clears the sticky flag and the bubble counter.
        tick(); jalr_id = 1; expect_o("rst_w_id", O_IDLE, 0);
        tick(); expect_o("rst_w_wait", O_WAIT, 0);
        te = 1'b0; exp_bub = 0;
        tick(); rst = 1; expect_o("rst_w_rst", O_INIT, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_o($sformatf("rst_w_init%0d", i), O_INIT, 1);
        end
        tick(); expect_o("rst_w_run", O_IDLE, 0);

        @(negedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
